// File: rtl/piso_serializer_pkg.sv
// Shared types and constants for the parallel-in, serial-out unloader.
package piso_serializer_pkg;

    typedef enum logic {IDLE, SHIFT} ser_state_t;

    localparam int unsigned SER_N_DEFAULT = 4;

    // Bit-counter width: max(1, clog2(n)).
    function automatic int unsigned ser_cnt_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Parallel-word input and serial-bit output handshakes of the serializer.
interface piso_serializer_if #(
    parameter int unsigned N = piso_serializer_pkg::SER_N_DEFAULT
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_bit;
    logic         out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_bit, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_bit, out_last
    );
endinterface

// File: rtl/piso_serializer.sv
// Loads an N-bit word on valid/ready and shifts it out one bit per serial transfer,
// flagging the final bit; a waiting word is loaded on the last-bit edge with no bubble.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int unsigned N         = SER_N_DEFAULT,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    piso_serializer_if.slave  bus,
    output logic              busy
);
    localparam int unsigned   CW       = ser_cnt_width(N);
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    ser_state_t     state_q, state_d;
    logic [N-1:0]   shreg_q, shreg_d;
    logic [N-1:0]   shifted;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           accept;
    logic           xfer;

    assign bus.out_valid = (state_q == SHIFT);
    assign bus.out_bit   = MSB_FIRST ? shreg_q[N-1] : shreg_q[0];
    assign bus.out_last  = (state_q == SHIFT) && (cnt_q == LAST_IDX);
    assign busy          = (state_q == SHIFT);

    assign xfer         = bus.out_valid && bus.out_ready;
    // Ready early on the last-bit transfer so the next word loads on the same edge.
    assign bus.in_ready = !rst && ((state_q == IDLE) || (xfer && bus.out_last));
    assign accept       = bus.in_valid && bus.in_ready;

    assign shifted = MSB_FIRST ? {shreg_q[N-2:0], 1'b0} : {1'b0, shreg_q[N-1:1]};

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (accept) begin
            shreg_d = bus.in_data;
            cnt_d   = '0;
            state_d = SHIFT;
        end else if (xfer) begin
            shreg_d = shifted;
            if (bus.out_last) begin
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: MSB-first instance plus an LSB-first instance.
module tb_piso_serializer;
    localparam int unsigned N = 4;

    logic clk;
    logic rst;
    logic busy;
    logic busy_l;

    piso_serializer_if #(.N(N)) bus   ();
    piso_serializer_if #(.N(N)) bus_l ();

    piso_serializer #(.N(N), .MSB_FIRST(1'b1)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
    );

    piso_serializer #(.N(N), .MSB_FIRST(1'b0)) dut_l (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus_l.slave),
        .busy (busy_l)
    );

    int checks   = 0;
    int failures = 0;

    // Expected {bit, last} pairs, oldest first.
    logic [1:0] exp_q[$];
    logic [1:0] exp_l[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [N-1:0] w, input bit msb);
        logic [1:0] e;
        int idx;
        for (int i = 0; i < N; i++) begin
            idx = msb ? (N - 1 - i) : i;
            e   = {w[idx], (i == N - 1) ? 1'b1 : 1'b0};
            if (msb) exp_q.push_back(e);
            else     exp_l.push_back(e);
        end
    endtask

    task automatic scoreboard_monitor();
        logic [1:0] e;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL msb_stream: unexpected bit=%b last=%b, scoreboard empty", bus.out_bit, bus.out_last);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.out_bit, bus.out_last} !== e) begin
                        failures++;
                        $display("FAIL msb_stream: bit/last=%b%b required %b%b at %0t", bus.out_bit, bus.out_last, e[1], e[0], $time);
                    end
                end
            end
            if (!rst && bus_l.out_valid === 1'b1 && bus_l.out_ready === 1'b1) begin
                checks++;
                if (exp_l.size() == 0) begin
                    failures++;
                    $display("FAIL lsb_stream: unexpected bit=%b last=%b, scoreboard empty", bus_l.out_bit, bus_l.out_last);
                end else begin
                    e = exp_l.pop_front();
                    if ({bus_l.out_bit, bus_l.out_last} !== e) begin
                        failures++;
                        $display("FAIL lsb_stream: bit/last=%b%b required %b%b at %0t", bus_l.out_bit, bus_l.out_last, e[1], e[0], $time);
                    end
                end
            end
        end
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle: out_valid=%b busy=%b required 0 0", name, bus.out_valid, busy);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: %0d expected bits never emitted, required 0", name, exp_q.size());
        end
    endtask

    task automatic accept_word(input logic [N-1:0] w, input string name);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_in_ready: in_ready=%b required 1", name, bus.in_ready);
        end
        push_word(w, 1'b1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 4'b1111;
        bus.out_ready = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_out_valid: out_valid=%b required 0", bus.out_valid);
            end
            checks++;
            if (busy !== 1'b0 || busy_l !== 1'b0) begin
                failures++;
                $display("FAIL reset_busy: busy=%b busy_l=%b required 0 0", busy, busy_l);
            end
            checks++;
            if (bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL reset_in_ready: in_ready=%b required 0", bus.in_ready);
            end
            tick();
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b required 1 0", bus.in_ready, bus.out_valid);
        end
        tick();
    endtask

    task automatic test_single();
        accept_word(4'b1010, "single");
        for (int c = 1; c <= N; c++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || busy !== 1'b1) begin
                failures++;
                $display("FAIL single_valid c%0d: out_valid=%b busy=%b required 1 1", c, bus.out_valid, busy);
            end
            tick();
        end
        check_idle("single");
        tick();
    endtask

    task automatic test_back_to_back();
        logic exp_rdy;
        accept_word(4'b1010, "b2b");
        bus.in_valid = 1'b1;
        for (int c = 1; c <= 2 * N; c++) begin
            if (c == N) bus.in_data = 4'b1100;
            @(negedge clk);
            exp_rdy = (c == N || c == 2 * N);
            checks++;
            if (bus.out_valid !== 1'b1) begin
                failures++;
                $display("FAIL b2b_valid c%0d: out_valid=%b required 1", c, bus.out_valid);
            end
            checks++;
            if (bus.in_ready !== exp_rdy) begin
                failures++;
                $display("FAIL b2b_in_ready c%0d: in_ready=%b required %b", c, bus.in_ready, exp_rdy);
            end
            if (c == N) push_word(4'b1100, 1'b1);
            tick();
            if (c == N) bus.in_valid = 1'b0;
        end
        check_idle("b2b");
        tick();
    endtask

    task automatic test_backpressure();
        accept_word(4'b1010, "bp");
        tick();
        tick();
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_bit !== 1'b1 || bus.out_last !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold c%0d: valid/bit/last=%b%b%b required 110", c, bus.out_valid, bus.out_bit, bus.out_last);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        tick();
        check_idle("bp");
        tick();
    endtask

    task automatic test_reset_mid_word();
        accept_word(4'b1010, "rstmid");
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        bus.in_valid = 1'b1;
        bus.in_data  = 4'b0110;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_abort: out_valid=%b busy=%b required 0 0", bus.out_valid, busy);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_in_ready: in_ready=%b required 1", bus.in_ready);
        end
        push_word(4'b0110, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        for (int c = 1; c <= N; c++) tick();
        check_idle("rstmid");
        tick();
    endtask

    task automatic test_lsb_first();
        bus_l.in_valid = 1'b1;
        bus_l.in_data  = 4'b1100;
        @(negedge clk);
        checks++;
        if (bus_l.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL lsb_in_ready: in_ready=%b required 1", bus_l.in_ready);
        end
        push_word(4'b1100, 1'b0);
        tick();
        bus_l.in_valid = 1'b0;
        for (int c = 1; c <= N; c++) begin
            @(negedge clk);
            checks++;
            if (bus_l.out_valid !== 1'b1 || busy_l !== 1'b1) begin
                failures++;
                $display("FAIL lsb_valid c%0d: out_valid=%b busy=%b required 1 1", c, bus_l.out_valid, busy_l);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (bus_l.out_valid !== 1'b0 || exp_l.size() != 0) begin
            failures++;
            $display("FAIL lsb_idle: out_valid=%b pending=%0d required 0 0", bus_l.out_valid, exp_l.size());
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.out_ready   = 1'b1;
        bus_l.in_valid  = 1'b0;
        bus_l.in_data   = '0;
        bus_l.out_ready = 1'b1;
        fork
            scoreboard_monitor();
        join_none
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_word();
        test_lsb_first();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
